demux1x2_tdm: RTL and testbench
===============================

DEMUX1X2_TDM -- requirements
Module: demux1x2_tdm

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the bit width of each channel word.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-004 The module SHALL have port din, input, 1 bit, the serial TDM data bit.
REQ-005 The module SHALL have port din_valid, input, 1 bit, which qualifies din; a bit is accepted only when din_valid=1.
REQ-006 The module SHALL have port sync, input, 1 bit, which marks the accepted bit as channel A bit 0, the first bit of a frame.
REQ-007 The module SHALL have port a_out, output, WIDTH bits, the last complete channel-A word.
REQ-008 The module SHALL have port b_out, output, WIDTH bits, the last complete channel-B word.
REQ-009 The module SHALL have port out_valid, output, 1 bit, a one-cycle pulse when a_out and b_out update.
REQ-010 The module SHALL have port frame_err, output, 1 bit, a one-cycle pulse on frame restart or abort.

Function
REQ-011 The frame format SHALL be 2*WIDTH accepted bits, interleaved A0,B0,A1,B1,... and LSB first.
REQ-012 The FSM SHALL have states IDLE and RECV.
REQ-013 In IDLE, an accepted bit with sync=1 SHALL be stored as A0, set bit_cnt=1 and move to RECV.
REQ-014 In IDLE, accepted bits with sync=0 SHALL be discarded silently.
REQ-015 In RECV, an accepted bit SHALL go to channel A when bit_cnt is even and to channel B when it is odd, at index bit_cnt/2.
REQ-016 When the accepted bit has bit_cnt=2*WIDTH-1, the FSM SHALL return to IDLE, and on the next edge the assembled words SHALL be copied to a_out and b_out with out_valid=1 for exactly one cycle.
REQ-017 Cycles with din_valid=0 SHALL hold all state, so gaps of any length inside a frame are allowed.
REQ-018 If sync=1 is accepted in RECV, the partial frame SHALL be discarded, the bit SHALL be taken as the new A0 with bit_cnt=1 and the FSM staying in RECV, and frame_err SHALL pulse for one cycle on the next edge.
REQ-019 a_out and b_out SHALL hold their value between out_valid pulses; partial frames SHALL never alter them.
REQ-020 If sync=1 arrives together with the last bit of a frame (bit_cnt=2*WIDTH-1), it SHALL be treated as a restart per REQ-018, with no out_valid pulse.
REQ-021 bit_cnt SHALL be $clog2(2*WIDTH) bits wide and SHALL never wrap; it returns to 0 only via IDLE.

Reset
REQ-022 When rst_n=0, the block SHALL immediately, without waiting for clk, force state=IDLE, bit_cnt=0, the internal words to 0, a_out=0, b_out=0, out_valid=0 and frame_err=0.
REQ-023 A reset during RECV SHALL abandon the frame, with no out_valid or frame_err pulse.
REQ-024 After rst_n deasserts, the first accepted sync SHALL start a frame normally.

Structure
REQ-025 The state encodings (IDLE=1'b0, RECV=1'b1) SHALL live in a shared include file, demux_defs.vh, pulled in with `include.
REQ-026 Channel storage SHALL use one sub-module, shreg_lsb, a WIDTH-bit register with a bit-indexed write enable and an asynchronous active-low clear, instantiated twice (A and B).
REQ-027 out_valid and frame_err SHALL be driven directly from flip-flops, with no combinational path from the inputs.

Verification (WIDTH=4)
REQ-028 Frame with A=4'hA and B=4'h3:
- stimulus: din=0,1,1,1,0,0,1,0 on 8 consecutive cycles, din_valid=1, sync=1 on the first bit only;
- required: out_valid=1 one cycle after the 8th bit, with a_out=4'hA and b_out=4'h3.
REQ-029 The same frame with din_valid=0 for 3 cycles inserted after bit 4 SHALL give an identical result, delayed by 3 cycles.
REQ-030 Restart mid-frame:
- stimulus: 5 bits of a frame, then sync=1 and a full frame with A=4'h5, B=4'hC;
- required: one frame_err pulse, then out_valid with a_out=4'h5 and b_out=4'hC;
- required: no out_valid for the aborted frame.
REQ-031 Reset mid-frame:
- stimulus: rst_n=0 pulsed between clk edges after bit 3;
- required: outputs 0 immediately; no pulse; the next full frame decodes correctly.
REQ-032 Idle noise: 6 accepted bits with sync=0 SHALL produce no pulses and leave a_out and b_out unchanged.

Source files
------------

// File: rtl/demux1x2_tdm_pkg.sv
// Common types and helpers for the 1-to-2 TDM demultiplexer.
package demux1x2_tdm_pkg;
`include "demux_defs.vh"

  typedef enum logic {
    IDLE = `DEMUX_IDLE,
    RECV = `DEMUX_RECV
  } state_e;

  // Width of a bit index into one channel word; kept at least 1 for WIDTH=1.
  function automatic int idx_w(input int width);
    int w;
    w = $clog2(2 * width) - 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux_defs.vh
// Shared FSM state encodings for the TDM demultiplexer.
`ifndef DEMUX_DEFS_VH
`define DEMUX_DEFS_VH
`define DEMUX_IDLE 1'b0
`define DEMUX_RECV 1'b1
`endif

// File: rtl/shreg_lsb.sv
// WIDTH-bit word register with a single bit-indexed write port,
// synchronous clear and asynchronous active-low clear.
module shreg_lsb
  import demux1x2_tdm_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = idx_w(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [IW-1:0]    idx_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // A clear and a write in the same cycle leave only the written bit set.
  always_comb begin
    q_d = clr_i ? '0 : q_q;
    if (we_i) q_d[idx_i] = d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/demux1x2_tdm.sv
// Serial TDM demultiplexer: splits an interleaved LSB-first bit stream
// into channel A and channel B words, framed by a sync marker.
module demux1x2_tdm
  import demux1x2_tdm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             out_valid,
  output logic             frame_err
);

  localparam int             CW   = $clog2(2 * WIDTH);
  localparam int             IW   = idx_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(2 * WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             out_valid_q, frame_err_q;
  logic [WIDTH-1:0] a_out_q, b_out_q;

  logic             clr_words;
  logic             we_a, we_b;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] word_a, word_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    clr_words = 1'b0;
    we_a      = 1'b0;
    we_b      = 1'b0;
    idx       = IW'(cnt_q >> 1);
    if (din_valid) begin
      if (sync) begin
        // Sync always (re)starts a frame; inside RECV it discards the partial one.
        clr_words = 1'b1;
        we_a      = 1'b1;
        idx       = '0;
        cnt_d     = CW'(1);
        state_d   = RECV;
        err_d     = (state_q == RECV);
      end else if (state_q == RECV) begin
        we_a = ~cnt_q[0];
        we_b = cnt_q[0];
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  shreg_lsb #(.WIDTH(WIDTH), .IW(IW)) u_word_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr_words),
    .we_i   (we_a),
    .idx_i  (idx),
    .d_i    (din),
    .q_o    (word_a)
  );

  shreg_lsb #(.WIDTH(WIDTH), .IW(IW)) u_word_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr_words),
    .we_i   (we_b),
    .idx_i  (idx),
    .d_i    (din),
    .q_o    (word_b)
  );

  // Pulses are registered twice: event flag first, then the output flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      a_out_q     <= '0;
      b_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_valid_q <= done_q;
      frame_err_q <= err_q;
      if (done_q) begin
        a_out_q <= word_a;
        b_out_q <= word_b;
      end
    end
  end

  assign a_out     = a_out_q;
  assign b_out     = b_out_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_demux1x2_tdm.sv
// Scoreboard bench for demux1x2_tdm (WIDTH=4) using directed frames.
module tb_demux1x2_tdm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] a_out, b_out;
  logic       out_valid, frame_err;

  typedef struct packed {
    logic       is_err;
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   valid_cyc = -1;

  demux1x2_tdm #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .sync      (sync),
    .a_out     (a_out),
    .b_out     (b_out),
    .out_valid (out_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        valid_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("event_kind_valid", {31'd0, e.is_err}, 32'd0);
          check("a_out", {28'd0, a_out}, {28'd0, e.a});
          check("b_out", {28'd0, b_out}, {28'd0, e.b});
        end
      end
      if (frame_err) begin
        if (exp_q.size() == 0) check("unexpected_frame_err", {31'd0, frame_err}, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("event_kind_err", {31'd0, e.is_err}, 32'd1);
        end
      end
    end
  end

  task automatic drive(input logic d, input logic s);
    @(negedge clk);
    din = d; sync = s; din_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0; sync = 1'b0;
    end
  endtask

  // Sends the first nbits of frame (a,b), optionally pausing after gap_after bits.
  task automatic send_frame(input logic [3:0] a, input logic [3:0] b, input int nbits,
                            input int gap_after, input int gap_len);
    for (int k = 0; k < nbits; k++) begin
      drive((k % 2 == 0) ? a[k/2] : b[k/2], k == 0);
      if (k == 0) start_cyc = cyc;
      if (gap_len > 0 && k + 1 == gap_after) idle(gap_len);
    end
  endtask

  initial begin
    int v1[8] = '{0, 1, 1, 1, 0, 0, 1, 0};
    int n1[6] = '{1, 0, 1, 1, 0, 1};

    #1 rst_n = 1'b0;
    #1;
    check("reset_a_out", {28'd0, a_out}, 32'd0);
    check("reset_b_out", {28'd0, b_out}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Basic frame A=A, B=3 from the hand-written bit vector.
    exp_q.push_back('{1'b0, 4'hA, 4'h3});
    for (int k = 0; k < 8; k++) begin
      drive(v1[k][0], k == 0);
      if (k == 0) start_cyc = cyc;
    end
    idle(5);
    check("latency_plain", valid_cyc - start_cyc, 32'd9);

    // Same frame with a 3-cycle gap after bit 4.
    exp_q.push_back('{1'b0, 4'hA, 4'h3});
    send_frame(4'hA, 4'h3, 8, 4, 3);
    idle(5);
    check("latency_gap", valid_cyc - start_cyc, 32'd12);

    // Restart after 5 bits.
    send_frame(4'hF, 4'hF, 5, 0, 0);
    exp_q.push_back('{1'b1, 4'h0, 4'h0});
    exp_q.push_back('{1'b0, 4'h5, 4'hC});
    send_frame(4'h5, 4'hC, 8, 0, 0);
    idle(5);

    // Asynchronous reset mid-frame after bit 3.
    send_frame(4'hF, 4'hF, 3, 0, 0);
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_a_out", {28'd0, a_out}, 32'd0);
    check("midreset_b_out", {28'd0, b_out}, 32'd0);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    exp_q.push_back('{1'b0, 4'h9, 4'h6});
    send_frame(4'h9, 4'h6, 8, 0, 0);
    idle(5);

    // Idle noise without sync.
    for (int k = 0; k < 6; k++) drive(n1[k][0], 1'b0);
    idle(5);
    check("noise_a_hold", {28'd0, a_out}, 32'h9);
    check("noise_b_hold", {28'd0, b_out}, 32'h6);

    // Sync coinciding with the last bit of a frame.
    send_frame(4'hF, 4'h0, 7, 0, 0);
    exp_q.push_back('{1'b1, 4'h0, 4'h0});
    exp_q.push_back('{1'b0, 4'h3, 4'hA});
    send_frame(4'h3, 4'hA, 8, 0, 0);
    idle(6);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
